// File: rtl/comp_pipe.sv
// rtl/comp_pipe.sv - two-stage pipelined RISC-V compare unit (EQ/NE/LT/GE/LTU/GEU)
//
// Stage 1 splits the operands into CHUNK-bit slices and registers per-chunk
// equal / less-than flags. Stage 2 reduces them to the selected relation and
// holds it in the output register. Fixed latency of two accepted edges.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_flush               synchronous kill of both in-flight entries
//   i_valid/o_ready       request handshake
//   i_op                  funct3 (000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU)
//   i_a, i_b, i_tag       operands and sideband tag
//   o_valid/i_ready       result handshake
//   o_taken, o_result     relation result, and the same zero-extended to WIDTH
//   o_tag, o_illegal      tag of the result, op was 010/011
module comp_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic [WIDTH-1:0] o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_illegal
);

  localparam int N = WIDTH / CHUNK;

  logic             s1_v_q;
  logic             s2_v_q;
  logic [N-1:0]     s1_eq_q, s1_eq_d;
  logic [N-1:0]     s1_lt_q, s1_lt_d;
  logic [2:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_ill_q;

  logic             taken_q, taken_d;
  logic [TAG_W-1:0] tag_q;
  logic             ill_q;

  logic             accept;
  logic             s2_adv;
  logic             s2_free;
  logic             signed_op;
  logic             illegal_op;
  logic [WIDTH-1:0] a_cmp, b_cmp;
  logic             all_eq;
  logic             lt;

  assign s2_adv  = s1_v_q && (!s2_v_q || i_ready);
  // Combinational from i_ready on purpose: a full pipe can still take a new
  // request in the same cycle that the consumer drains the output.
  assign o_ready = !s1_v_q || s2_adv;
  assign accept  = i_valid && o_ready;
  assign s2_free = s2_v_q && i_ready;

  assign signed_op  = (i_op == 3'b100) || (i_op == 3'b101);
  assign illegal_op = (i_op[2:1] == 2'b01);

  // Flipping the sign bit maps two's complement order onto unsigned order,
  // so one unsigned chunk comparator serves both signed and unsigned ops.
  always_comb begin
    a_cmp = i_a;
    b_cmp = i_b;
    a_cmp[WIDTH-1] = i_a[WIDTH-1] ^ signed_op;
    b_cmp[WIDTH-1] = i_b[WIDTH-1] ^ signed_op;
  end

  always_comb begin
    s1_eq_d = '0;
    s1_lt_d = '0;
    for (int k = 0; k < N; k++) begin
      s1_eq_d[k] = (a_cmp[k*CHUNK +: CHUNK] == b_cmp[k*CHUNK +: CHUNK]);
      s1_lt_d[k] = (a_cmp[k*CHUNK +: CHUNK] <  b_cmp[k*CHUNK +: CHUNK]);
    end
  end

  // Ascending scan: the last differing chunk seen is the most significant one,
  // so its lt flag decides the ordering.
  always_comb begin
    all_eq = &s1_eq_q;
    lt     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!s1_eq_q[k]) lt = s1_lt_q[k];
    end
  end

  always_comb begin
    taken_d = 1'b0;
    if (!s1_ill_q) begin
      case (s1_op_q)
        3'b000:  taken_d = all_eq;
        3'b001:  taken_d = !all_eq;
        3'b100,
        3'b110:  taken_d = lt;
        3'b101,
        3'b111:  taken_d = !lt;
        default: taken_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      taken_q <= 1'b0;
      tag_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      if (i_flush) begin
        s1_v_q <= 1'b0;
        s2_v_q <= 1'b0;
      end else begin
        if (accept)      s1_v_q <= 1'b1;
        else if (s2_adv) s1_v_q <= 1'b0;
        if (s2_adv)       s2_v_q <= 1'b1;
        else if (s2_free) s2_v_q <= 1'b0;
      end
      if (s2_adv) begin
        taken_q <= taken_d;
        tag_q   <= s1_tag_q;
        ill_q   <= s1_ill_q;
      end
    end
  end

  // Stage-1 payload carries no reset; it is qualified by s1_v_q.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      s1_eq_q  <= s1_eq_d;
      s1_lt_q  <= s1_lt_d;
      s1_op_q  <= i_op;
      s1_tag_q <= i_tag;
      s1_ill_q <= illegal_op;
    end
  end

  assign o_valid   = s2_v_q;
  assign o_taken   = taken_q;
  assign o_result  = {{(WIDTH-1){1'b0}}, taken_q};
  assign o_tag     = tag_q;
  assign o_illegal = ill_q;

endmodule

// File: tb/tb_comp_pipe.sv
// tb/tb_comp_pipe.sv - self-checking bench for comp_pipe (32/8, 64/16, 8/8)
module tb_comp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  op = 3'b000;
  logic [4:0]  tag = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] a64 = '0, b64 = '0;
  logic [7:0]  a8 = '0, b8 = '0;

  logic        r32, v32, t32, il32;
  logic [31:0] res32;
  logic [4:0]  tg32;
  logic        r64, v64, t64, il64;
  logic [63:0] res64;
  logic [4:0]  tg64;
  logic        r8, v8, t8, il8;
  logic [7:0]  res8;
  logic [4:0]  tg8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  comp_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(5)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(r32),
    .i_op(op), .i_a(a32), .i_b(b32), .i_tag(tag), .o_valid(v32), .i_ready(out_ready),
    .o_taken(t32), .o_result(res32), .o_tag(tg32), .o_illegal(il32));

  comp_pipe #(.WIDTH(64), .CHUNK(16), .TAG_W(5)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(r64),
    .i_op(op), .i_a(a64), .i_b(b64), .i_tag(tag), .o_valid(v64), .i_ready(out_ready),
    .o_taken(t64), .o_result(res64), .o_tag(tg64), .o_illegal(il64));

  comp_pipe #(.WIDTH(8), .CHUNK(8), .TAG_W(5)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(r8),
    .i_op(op), .i_a(a8), .i_b(b8), .i_tag(tag), .o_valid(v8), .i_ready(out_ready),
    .o_taken(t8), .o_result(res8), .o_tag(tg8), .o_illegal(il8));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference relation: signed compares done by left-aligning the w-bit
  // values into 64 bits so $signed sees the right sign bit.
  function automatic logic ref_taken(input logic [2:0] o, input logic [63:0] a,
                                     input logic [63:0] b, input int w);
    logic [63:0] sa, sb;
    sa = a << (64 - w);
    sb = b << (64 - w);
    case (o)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(sa) <  $signed(sb);
      3'd5:    return $signed(sa) >= $signed(sb);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic       taken;
    logic       ill;
    logic [4:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t q8[$];

  function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b, input int w);
    exp_t e;
    e.taken = ref_taken(op, a, b, w);
    e.ill   = (op[2:1] == 2'b01);
    e.tag   = tag;
    return e;
  endfunction

  always @(negedge rst_n) begin
    q32.delete(); q64.delete(); q8.delete();
  end

  // Scoreboard: inputs settle one time unit after each rising edge, so the
  // falling edge sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      q32.delete(); q64.delete(); q8.delete();
    end else begin
      if (v32 && out_ready) begin
        if (q32.size() == 0) check("w32_spurious_out", 1, 0);
        else begin
          e = q32.pop_front();
          check("w32_taken", 64'(t32), 64'(e.taken));
          check("w32_result", 64'(res32), 64'(e.taken));
          check("w32_tag", 64'(tg32), 64'(e.tag));
          check("w32_illegal", 64'(il32), 64'(e.ill));
        end
      end
      if (v64 && out_ready) begin
        if (q64.size() == 0) check("w64_spurious_out", 1, 0);
        else begin
          e = q64.pop_front();
          check("w64_taken", 64'(t64), 64'(e.taken));
          check("w64_result", res64, 64'(e.taken));
          check("w64_tag", 64'(tg64), 64'(e.tag));
          check("w64_illegal", 64'(il64), 64'(e.ill));
        end
      end
      if (v8 && out_ready) begin
        if (q8.size() == 0) check("w8_spurious_out", 1, 0);
        else begin
          e = q8.pop_front();
          check("w8_taken", 64'(t8), 64'(e.taken));
          check("w8_result", 64'(res8), 64'(e.taken));
          check("w8_tag", 64'(tg8), 64'(e.tag));
          check("w8_illegal", 64'(il8), 64'(e.ill));
        end
      end
      if (in_valid && r32) q32.push_back(mk({32'b0, a32}, {32'b0, b32}, 32));
      if (in_valid && r64) q64.push_back(mk(a64, b64, 64));
      if (in_valid && r8)  q8.push_back(mk({56'b0, a8}, {56'b0, b8}, 8));
    end
  end

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] m, v;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'd1 << (w - 1);
      3:       v = (64'd1 << (w - 1)) - 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & m;
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        taken;
    logic        ill;
  } vec_t;

  vec_t vt[12];

  // One request on an idle pipe; result must appear after exactly two edges.
  task automatic send_one(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input logic exp_taken, input logic exp_ill);
    op = o; a32 = a; b32 = b; tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_not_early", 64'(v32), 64'd0);
    @(posedge clk); #1;
    check("lat_valid", 64'(v32), 64'd1);
    check("vec_taken", 64'(t32), 64'(exp_taken));
    check("vec_result", 64'(res32), 64'(exp_taken));
    check("vec_tag", 64'(tg32), 64'(t));
    check("vec_illegal", 64'(il32), 64'(exp_ill));
    @(posedge clk); #1;
  endtask

  logic [2:0]  s_op[6];
  logic [31:0] s_a[6];
  logic [31:0] s_b[6];
  logic        s_exp[6];

  initial begin
    int acc;

    vt[0]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0};
    vt[1]  = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vt[2]  = '{3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vt[3]  = '{3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0};
    vt[4]  = '{3'b000, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0};
    vt[5]  = '{3'b101, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0};
    vt[6]  = '{3'b111, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0};
    vt[7]  = '{3'b100, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b0};
    vt[8]  = '{3'b001, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0};
    vt[9]  = '{3'b110, 32'h0100_0000, 32'h00FF_FFFF, 1'b0, 1'b0};
    vt[10] = '{3'b010, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    vt[11] = '{3'b011, 32'h0000_0005, 32'h0000_0009, 1'b0, 1'b1};

    s_op[0] = 3'b000; s_a[0] = 32'd5;          s_b[0] = 32'd5;          s_exp[0] = 1'b1;
    s_op[1] = 3'b001; s_a[1] = 32'd5;          s_b[1] = 32'd5;          s_exp[1] = 1'b0;
    s_op[2] = 3'b101; s_a[2] = 32'h8000_0000;  s_b[2] = 32'h7FFF_FFFF;  s_exp[2] = 1'b0;
    s_op[3] = 3'b111; s_a[3] = 32'h8000_0000;  s_b[3] = 32'h7FFF_FFFF;  s_exp[3] = 1'b1;
    s_op[4] = 3'b100; s_a[4] = 32'd7;          s_b[4] = 32'd7;          s_exp[4] = 1'b0;
    s_op[5] = 3'b111; s_a[5] = 32'd0;          s_b[5] = 32'd0;          s_exp[5] = 1'b1;

    // Reset state
    #23;
    check("rst_valid32", 64'(v32), 64'd0);
    check("rst_taken32", 64'(t32), 64'd0);
    check("rst_result32", 64'(res32), 64'd0);
    check("rst_tag32", 64'(tg32), 64'd0);
    check("rst_illegal32", 64'(il32), 64'd0);
    check("rst_valid64", 64'(v64), 64'd0);
    check("rst_valid8", 64'(v8), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 64'(r32), 64'd1);

    // Table-driven single requests
    for (int i = 0; i < 12; i++)
      send_one(vt[i].op, vt[i].a, vt[i].b, 5'(i + 3), vt[i].taken, vt[i].ill);

    // Back-to-back stream: six results on six consecutive cycles
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j < 6) begin
        in_valid = 1'b1; op = s_op[j]; a32 = s_a[j]; b32 = s_b[j]; tag = 5'(j + 20);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (j >= 1 && j <= 6) begin
        check("stream_valid", 64'(v32), 64'd1);
        check("stream_taken", 64'(t32), 64'(s_exp[j-1]));
        check("stream_tag", 64'(tg32), 64'(j - 1 + 20));
      end
    end
    @(posedge clk); #1;
    check("stream_drained", 64'(v32), 64'd0);

    // Backpressure: consumer stalls for four cycles while requests keep coming
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      op = 3'b000;
      a32 = (acc == 1) ? 32'd1 : 32'd3;
      b32 = (acc == 1) ? 32'd2 : 32'd3;
      tag = 5'(acc + 1);
      #1;
      if (r32) acc++;
      if (c >= 2) begin
        check("bp_hold_valid", 64'(v32), 64'd1);
        check("bp_hold_taken", 64'(t32), 64'd1);
        check("bp_hold_tag", 64'(tg32), 64'd1);
      end
      @(posedge clk); #1;
    end
    check("bp_accepted", 64'(acc), 64'd2);
    check("bp_ready_low", 64'(r32), 64'd0);
    check("bp_hold_tag_end", 64'(tg32), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_first_valid", 64'(v32), 64'd1);
    check("bp_first_tag", 64'(tg32), 64'd1);
    @(posedge clk); #1;
    check("bp_second_valid", 64'(v32), 64'd1);
    check("bp_second_tag", 64'(tg32), 64'd2);
    check("bp_second_taken", 64'(t32), 64'd0);
    @(posedge clk); #1;
    check("bp_no_dup", 64'(v32), 64'd0);

    // Flush kills both stages and the request presented alongside it
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b000; a32 = 32'd1; b32 = 32'd1; tag = 5'd10;
    @(posedge clk); #1;
    tag = 5'd11;
    @(posedge clk); #1;
    tag = 5'd12; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("flush_valid_low", 64'(v32), 64'd0);
      check("flush_ready", 64'(r32), 64'd1);
      @(posedge clk); #1;
    end
    send_one(3'b110, 32'd2, 32'd9, 5'd13, 1'b1, 1'b0);

    // Asynchronous reset while a result is being held
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b000; a32 = 32'd0; b32 = 32'd0; tag = 5'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(v32), 64'd1);
    check("pre_rst_tag", 64'(tg32), 64'd7);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(v32), 64'd0);
    check("arst_taken", 64'(t32), 64'd0);
    check("arst_result", 64'(res32), 64'd0);
    check("arst_tag", 64'(tg32), 64'd0);
    check("arst_illegal", 64'(il32), 64'd0);
    #4;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_rst_idle", 64'(v32), 64'd0);
    end

    // Randomized traffic on all three widths, checked by the scoreboard
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      op        = 3'($urandom_range(0, 7));
      tag       = 5'($urandom);
      a32 = 32'(rnd_op(32));
      b32 = ($urandom_range(0, 4) == 0) ? a32 : 32'(rnd_op(32));
      a64 = rnd_op(64);
      b64 = ($urandom_range(0, 4) == 0) ? a64 : rnd_op(64);
      a8  = 8'(rnd_op(8));
      b8  = ($urandom_range(0, 4) == 0) ? a8 : 8'(rnd_op(8));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("drain_q32", 64'(q32.size()), 64'd0);
    check("drain_q64", 64'(q64.size()), 64'd0);
    check("drain_q8", 64'(q8.size()), 64'd0);
    check("drain_valid", 64'({v32, v64, v8}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
